store_buffer: RTL and testbench

- FIFO write buffer between the pipeline memory stage and the data memory.
- Accepts stores from the pipeline (write enable, address, write data, 2-bit size code) and drains them to the data memory one per cycle, gated by a memory-ready handshake.
- Protects loads from reading stale data: any load that word-matches a pending store stalls the pipeline until that store drains.

---
 rtl/store_buffer.sv | 137 +++++++++++++
 tb/tb_store_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Circular FIFO write buffer between the memory stage and data memory, with word-granular load hazard detection.
// Optional STORE_BUF_FWD_EN: forward the youngest matching full-word store to an aligned load instead of stalling.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  input  logic [1:0]               st_size,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     stall,
  output logic                     ld_fwd_valid,
  output logic [DW-1:0]            ld_fwd_data,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wd,
  output logic [1:0]               mem_size,
  input  logic                     mem_ready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [1:0]       r_size [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_match;
  logic             w_hazard;
  logic             w_fwd_hit;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // A full buffer refuses the store even when the head drains this cycle.
  assign w_push  = st_valid && !w_full;
  assign w_pop   = !w_empty && mem_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign w_match[gi] = r_valid[gi] && (r_addr[gi][AW-1:2] == ld_addr[AW-1:2]);
    end
  endgenerate

  assign w_hazard = ld_valid && (|w_match);

`ifdef STORE_BUF_FWD_EN
  logic [PW-1:0] w_scan_idx;
  logic          w_young_any;
  logic [1:0]    w_young_size;
  logic [DW-1:0] w_young_data;

  // Scan oldest to youngest from the head; the last match is the youngest store.
  always_comb begin
    w_scan_idx   = r_rd_ptr;
    w_young_any  = 1'b0;
    w_young_size = 2'b00;
    w_young_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = r_rd_ptr + PW'(k);
      if (w_match[w_scan_idx]) begin
        w_young_any  = 1'b1;
        w_young_size = r_size[w_scan_idx];
        w_young_data = r_data[w_scan_idx];
      end
    end
  end

  assign w_fwd_hit    = w_hazard && w_young_any && (w_young_size == 2'b10) && (ld_addr[1:0] == 2'b00);
  assign ld_fwd_valid = w_fwd_hit;
  assign ld_fwd_data  = w_fwd_hit ? w_young_data : '0;
`else
  logic w_unused_ld_lo;

  assign w_unused_ld_lo = ^ld_addr[1:0];
  assign w_fwd_hit      = 1'b0;
  assign ld_fwd_valid   = 1'b0;
  assign ld_fwd_data    = '0;
`endif

  assign stall = (st_valid && w_full) || (w_hazard && !w_fwd_hit);

  assign mem_we   = !w_empty;
  assign mem_addr = r_addr[r_rd_ptr];
  assign mem_wd   = r_data[r_rd_ptr];
  assign mem_size = r_size[r_rd_ptr];
  assign empty    = w_empty;
  assign count    = r_count;

  // Payload storage carries no reset; only the valid bits and pointers define occupancy.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_addr[r_wr_ptr] <= st_addr;
      r_data[r_wr_ptr] <= st_data;
      r_size[r_wr_ptr] <= st_size;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue model predicts drain order, occupancy, stalls and forwarding.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [1:0]    st_size;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          stall;
  logic          ld_fwd_valid;
  logic [DW-1:0] ld_fwd_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [1:0]    mem_size;
  logic          mem_ready;
  logic          empty;
  logic [$clog2(DEPTH):0] count;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .stall(stall), .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_size(mem_size),
    .mem_ready(mem_ready), .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    s;
  } ent_t;

  ent_t m_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model check and update on the falling edge, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (mon_en) begin
      int            exp_cnt;
      bit            exp_full;
      bit            haz;
      bit            fwd;
      logic [1:0]    y_size;
      logic [DW-1:0] y_data;
      ent_t          e;
      exp_cnt  = m_q.size();
      exp_full = (exp_cnt == DEPTH);
      haz      = 1'b0;
      y_size   = 2'b00;
      y_data   = '0;
      foreach (m_q[i]) begin
        if (ld_valid && (m_q[i].a[AW-1:2] == ld_addr[AW-1:2])) begin
          haz    = 1'b1;
          y_size = m_q[i].s;
          y_data = m_q[i].d;
        end
      end
      fwd = FWD && haz && (y_size == 2'b10) && (ld_addr[1:0] == 2'b00);
      chk("count", count, exp_cnt);
      chk("count_le_depth", count > DEPTH, 0);
      chk("empty", empty, exp_cnt == 0);
      chk("mem_we", mem_we, exp_cnt != 0);
      chk("stall", stall, (st_valid && exp_full) || (haz && !fwd));
      chk("fwd_valid", ld_fwd_valid, fwd);
      chk("fwd_data", ld_fwd_data, fwd ? y_data : '0);
      if (reset) begin
        m_q.delete();
      end else begin
        if (exp_cnt != 0 && mem_ready) begin
          e = m_q.pop_front();
          chk("drain_addr", mem_addr, e.a);
          chk("drain_data", mem_wd, e.d);
          chk("drain_size", mem_size, e.s);
        end
        if (st_valid && !exp_full) m_q.push_back('{a: st_addr, d: st_data, s: st_size});
      end
    end
  end

  task automatic drive(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic [1:0] ss, input logic lv, input logic [AW-1:0] la,
                       input logic mr);
    st_valid  = sv;
    st_addr   = sa;
    st_data   = sd;
    st_size   = ss;
    ld_valid  = lv;
    ld_addr   = la;
    mem_ready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    drive(0, 0, 0, 0, 0, 0, 1);
    while (empty !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < 20, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_empty", empty, 1);
      chk("idle_count", count, 0);
      chk("idle_mem_we", mem_we, 0);
      chk("idle_stall", stall, 0);
      tick();
    end

    // Single store, one-cycle latency to mem_we
    drive(1, 32'h100, 32'hDEADBEEF, 2'b10, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("single_mem_we", mem_we, 1);
    chk("single_addr", mem_addr, 32'h100);
    chk("single_data", mem_wd, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("single_empty", empty, 1);
    tick();

    // Fill and back-pressure
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(4 * i), 32'hA000 + 32'(i), 2'b10, 0, 0, 0);
      tick();
    end
    drive(1, 32'h10, 32'hA004, 2'b10, 0, 0, 0);
    @(negedge clk);
    chk("full_count", count, 4);
    chk("full_stall", stall, 1);
    tick();
    drive(1, 32'h10, 32'hA004, 2'b10, 0, 0, 1);
    @(negedge clk);
    chk("full_pop_stall", stall, 1);
    tick();
    @(negedge clk);
    chk("retry_accept", stall, 0);
    tick();
    wait_drain();

    // Load hazard, word granular
    drive(1, 32'h203, 32'h000000AA, 2'b00, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h200, 0);
    @(negedge clk);
    chk("haz_stall", stall, 1);
    tick();
    drive(0, 0, 0, 0, 1, 32'h204, 0);
    @(negedge clk);
    chk("haz_other_word", stall, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h200, 1);
    @(negedge clk);
    chk("haz_pop_cycle", stall, 1);
    tick();
    @(negedge clk);
    chk("haz_after_pop", stall, 0);
    tick();
    wait_drain();

    // Forwarding of a full-word store, then a younger partial store over it
    drive(1, 32'h300, 32'h12345678, 2'b10, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h300, 0);
    @(negedge clk);
    chk("fwd_stall", stall, FWD ? 1'b0 : 1'b1);
    chk("fwd_valid_word", ld_fwd_valid, FWD);
    chk("fwd_data_word", ld_fwd_data, FWD ? 32'h12345678 : 32'h0);
    tick();
    drive(1, 32'h301, 32'h000000FF, 2'b00, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h300, 0);
    @(negedge clk);
    chk("partial_over_word", stall, 1);
    tick();
    wait_drain();

    // Simultaneous push and pop with pointer wrap; odd entries use size 11
    drive(1, 32'h400, 32'hB0, 2'b10, 0, 0, 0);
    tick();
    drive(1, 32'h404, 32'hB1, 2'b01, 0, 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h500 + 32'(4 * i), 32'hC0 + 32'(i), (i % 2 == 1) ? 2'b11 : 2'b10, 0, 0, 1);
      @(negedge clk);
      chk("pp_count", count, 2);
      tick();
    end
    wait_drain();

    // Reset mid-drain discards pending stores
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h600 + 32'(4 * i), 32'hD0 + 32'(i), 2'b10, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_mem_we", mem_we, 0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
